// File: rtl/accum_pkg.sv
// Shared types and default parameter values for the sample accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } accum_state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_COUNT  = 4;
  localparam int DEF_SUM_W  = 6;

endpackage

// File: rtl/accum_fsm.sv
// Sequencing for the accumulator: tracks IDLE/ACCUM/HOLD and the sample count,
// and produces the handshake outputs plus load/add/release strobes for the datapath.
module accum_fsm
  import accum_pkg::*;
#(
  parameter int COUNT = DEF_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load,
  output logic add,
  output logic release_res
);

  localparam int CNT_W = $clog2(COUNT + 1);

  accum_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             rst_q;
  logic             in_fire, out_fire;

  // rst_q marks the first cycle after reset so the input side stays closed one extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rst_q <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rst_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + CNT_W'(1);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = (COUNT == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_W'(COUNT)) state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (out_fire) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready    = (state != HOLD) && !rst && !rst_q;
    out_valid   = (state == HOLD) && !rst;
    load        = in_valid && in_ready && (state == IDLE) && !clear;
    add         = in_valid && in_ready && (state == ACCUM) && !clear;
    release_res = out_valid && out_ready;
  end

endmodule

// File: rtl/accum_4bit.sv
// Accumulates COUNT unsigned samples into a SUM_W-bit result with a sticky overflow flag.
// Define ACCUM_SAT_EN to saturate the sum on overflow; otherwise it wraps.
module accum_4bit
  import accum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COUNT  = DEF_COUNT,
  parameter int SUM_W  = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_data,
  output logic              out_ovf
);

  logic [SUM_W-1:0] acc;
  logic             ovf;
  logic [SUM_W:0]   sum;
  logic [SUM_W-1:0] acc_add;
  logic             load, add, release_res;

  accum_fsm #(
    .COUNT(COUNT)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .load        (load),
    .add         (add),
    .release_res (release_res)
  );

  // The extra top bit of sum is the carry that flags overflow.
  always_comb begin
    sum = {1'b0, acc} + (SUM_W + 1)'(in_data);
`ifdef ACCUM_SAT_EN
    acc_add = sum[SUM_W] ? {SUM_W{1'b1}} : sum[SUM_W-1:0];
`else
    acc_add = sum[SUM_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || clear || release_res) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= SUM_W'(in_data);
      ovf <= 1'b0;
    end else if (add) begin
      acc <= acc_add;
      ovf <= ovf | sum[SUM_W];
    end
  end

  always_comb begin
    out_data = out_valid ? acc : '0;
    out_ovf  = out_valid ? ovf : 1'b0;
  end

endmodule

// File: tb/tb_accum_4bit.sv
// Directed self-checking bench for accum_4bit; a second instance with SUM_W=5 covers overflow.
module tb_accum_4bit;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [5:0] out_data;
  logic       in_ready5, out_valid5, out_ovf5;
  logic [4:0] out_data5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accum_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  accum_4bit #(.DATA_W(4), .COUNT(4), .SUM_W(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready5),
    .in_data   (in_data),
    .out_valid (out_valid5),
    .out_ready (out_ready),
    .out_data  (out_data5),
    .out_ovf   (out_ovf5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 6'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got in_ready=%b out_valid=%b data=%0d ovf=%b exp 0 0 0 0",
               in_ready, out_valid, out_data, out_ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cycle_after got in_ready=%b exp 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release got in_ready=%b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [3:0] s [4] = '{4'd4, 4'd4, 4'd1, 4'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s[i];
      step();
      if (i < 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL basic_early_valid sample=%0d got=%b exp=0", i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'd12 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result got valid=%b data=%0d ovf=%b exp 1 12 0",
               out_valid, out_data, out_ovf);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 6'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_one_cycle got valid=%b data=%0d ovf=%b exp 0 0 0",
               out_valid, out_data, out_ovf);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] exp5;
`ifdef ACCUM_SAT_EN
    exp5 = 5'd31;
`else
    exp5 = 5'd28;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'd15;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid5 !== 1'b1 || out_data5 !== exp5 || out_ovf5 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sum5 got valid=%b data=%0d ovf=%b exp 1 %0d 1",
               out_valid5, out_data5, out_ovf5, exp5);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'd60 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_sum6 got valid=%b data=%0d ovf=%b exp 1 60 0",
               out_valid, out_data, out_ovf);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] s [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s[i];
      step();
    end
    in_data = 4'd9;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 6'd26 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_hold cycle=%0d got valid=%b data=%0d in_ready=%b exp 1 26 0",
                 c, out_valid, out_data, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'd26) begin
      failures++;
      $display("[TB] FAIL stall_release got valid=%b data=%0d exp 1 26", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_single got valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_no_repeat got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] s [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s[i];
      step();
      if (i < 3) begin
        in_valid = 1'b0; in_data = 4'd15;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL gaps_early_valid sample=%0d got=%b exp=0", i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'd10) begin
      failures++;
      $display("[TB] FAIL gaps_result got valid=%b data=%0d exp 1 10", out_valid, out_data);
    end
    step();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 4'd7;
      step();
    end
    clear = 1'b1; in_data = 4'd9;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'd2;
      step();
      if (i < 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL clear_early_valid sample=%0d got=%b exp=0", i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'd8 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_result got valid=%b data=%0d ovf=%b exp 1 8 0",
               out_valid, out_data, out_ovf);
    end
    step();
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'd3;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'd12) begin
      failures++;
      $display("[TB] FAIL rsthold_pending got valid=%b data=%0d exp 1 12", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 6'd0) begin
      failures++;
      $display("[TB] FAIL rsthold_drop got valid=%b data=%0d exp 0 0", out_valid, out_data);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rsthold_after got valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'd1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'd4 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rsthold_next got valid=%b data=%0d ovf=%b exp 1 4 0",
               out_valid, out_data, out_ovf);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_clear();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_4bit.md
ACCUM_4BIT -- requirements
Module: accum_4bit

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning the input operand width (the upstream adder sum width).
REQ-002 SHALL have parameter COUNT, default 4, range 1..16, meaning the number of input samples per accumulated result.
REQ-003 SHALL have parameter SUM_W, default 6, range DATA_W..16, meaning the accumulator and result width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-006 SHALL have port clear, input, 1, meaning a synchronous abort that discards the partial sum.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block can accept in_data.
REQ-009 SHALL have port in_data, input, DATA_W, meaning the unsigned sample from the upstream adder.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data and out_ovf hold a completed result.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-012 SHALL have port out_data, output, SUM_W, meaning the unsigned sum of COUNT samples.
REQ-013 SHALL have port out_ovf, output, 1, meaning the sum exceeded 2^SUM_W-1 at some point during the block.

Function
REQ-014 SHALL use the FSM states IDLE, ACCUM and HOLD.
REQ-015 SHALL define an input transfer as in_valid && in_ready at a rising edge, and an output transfer as out_valid && out_ready at a rising edge.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = 0 in HOLD; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL, in IDLE on a transfer, load acc = in_data zero-extended, cnt = 1 and ovf = 0, then go to ACCUM, or to HOLD if COUNT == 1.
REQ-018 SHALL, in ACCUM on a transfer, compute acc + in_data at SUM_W+1 bits, set ovf when bit SUM_W is 1 (sticky), increment cnt, and go to HOLD when the new cnt == COUNT.
REQ-019 SHALL hold acc, cnt and state in IDLE or ACCUM when no transfer occurs; gaps in in_valid are allowed.
REQ-020 SHALL assert out_valid only in HOLD; out_valid SHALL rise in the cycle after the COUNT-th input transfer (latency 1).
REQ-021 SHALL keep out_data and out_ovf stable while out_valid && !out_ready.
REQ-022 SHALL, on an output transfer, go to IDLE and drive acc = 0, ovf = 0 and cnt = 0.
REQ-023 SHALL drive out_data = 0 and out_ovf = 0 whenever out_valid = 0.
REQ-024 SHALL treat clear = 1 in any state as a return to IDLE with acc, cnt and ovf zeroed; clear SHALL override any same-cycle transfer, and a sample presented in that cycle SHALL be discarded.
REQ-025 SHALL use a cnt width of $clog2(COUNT+1).

Reset
REQ-026 SHALL, with rst = 1 at a rising edge, enter IDLE with acc = 0, cnt = 0 and ovf = 0; rst SHALL have priority over clear and all transfers.
REQ-027 SHALL, while rst is high and in the cycle after it, drive the outputs in_ready = 0, out_valid = 0, out_data = 0 and out_ovf = 0; in_ready SHALL return to 1 one cycle after rst deasserts.
REQ-028 SHALL treat a reset mid-operation (ACCUM or HOLD) as discarding the partial or pending result without emitting it.

Configuration
REQ-029 SHALL, with the macro ACCUM_SAT_EN defined, saturate acc to 2^SUM_W-1 on any overflowing addition and hold it there for the rest of the block.
REQ-030 SHALL, with ACCUM_SAT_EN undefined, wrap acc modulo 2^SUM_W; out_ovf SHALL behave identically in both builds.

Structure
REQ-031 SHALL place the state enum type (accum_state_t) and the default parameter constants in the package accum_pkg.
REQ-032 SHALL implement the FSM and counter in one sub-module, accum_fsm; the datapath (acc, ovf, saturation) SHALL be in accum_4bit.

Verification
REQ-033 SHALL verify, with defaults, samples 4, 4, 1, 3 sent back-to-back and out_ready = 1, that out_valid = 1 for one cycle with out_data = 12 and out_ovf = 0.
REQ-034 SHALL verify, with SUM_W = 5 and samples 15, 15, 15, 15, that out_ovf = 1 and out_data = 31 with ACCUM_SAT_EN and 28 without.
REQ-035 SHALL verify, with out_ready held 0 for 5 cycles after a result, that out_data stays stable, in_ready = 0, and a single result is accepted when out_ready rises.
REQ-036 SHALL verify, with in_valid toggling 1-0-1-0 over samples 1, 2, 3, 4, that the result is 10 and each sample is counted exactly once.
REQ-037 SHALL verify, with clear asserted after 2 samples and then samples 2, 2, 2, 2, that the next result is 8.
REQ-038 SHALL verify, with rst pulsed in HOLD, that out_valid drops to 0 with no output transfer and the next block of 1, 1, 1, 1 yields 4.
